autoconfig_z2: RTL and testbench

Zorro II AutoConfig responder for the on-card Fast RAM. Sits directly upstream of the Fast RAM address decoder. Answers the Kickstart configuration reads at $E80000 while unconfigured, captures the base address written by the OS, and then presents `BASE_RAM[7:5]` and `RAM_CONFIGURED_n` to the decoder. Passes the configuration chain on via `CFGOUT_n` once it is configured or told to shut up.

---
 rtl/autoconfig_pkg.sv | 26 ++
 rtl/autoconfig_z2_if.sv | 33 +++
 rtl/sync2.sv | 24 ++
 rtl/autoconfig_z2.sv | 128 ++++++++++++
 tb/tb_autoconfig_z2.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/autoconfig_pkg.sv
// Shared types and constants for the Zorro II AutoConfig responder.
// Holds the state encoding, register offsets and a nibble-select helper.
package autoconfig_pkg;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    CONFIG = 2'd1,
    SHUTUP = 2'd2
  } state_t;

  localparam logic [6:0] OFS_BASE     = 7'h48;
  localparam logic [6:0] OFS_BASE_LO  = 7'h4A;
  localparam logic [6:0] OFS_SHUTUP   = 7'h4C;
  localparam logic [7:0] AUTOCFG_PAGE = 8'hE8;
  localparam logic [3:0] TYPE_NIBBLE  = 4'hE;

  // idx 0 selects the most significant nibble of the 32-bit word.
  function automatic logic [3:0] pick_nibble(input logic [31:0] word, input logic [2:0] idx);
    logic [4:0]  sh;
    logic [31:0] shifted;
    sh      = {3'd7 - idx, 2'b00};
    shifted = word >> sh;
    return shifted[3:0];
  endfunction

endpackage

// File: rtl/autoconfig_z2_if.sv
// Bus bundle between the 68000 side and the AutoConfig responder / RAM decoder.
// Handshake: AS_n low frames one bus cycle with a single stable address; DS_n low marks valid write data.
interface autoconfig_z2_if;
  import autoconfig_pkg::*;

  logic [23:1]  A;
  logic [15:12] D_IN;
  logic         RW_n;
  logic         AS_n;
  logic         UDS_n;
  logic         LDS_n;
  logic         DS_n;
  logic         CFGIN_n;
  logic         JP4;

  logic [15:12] D_OUT;
  logic         D_OE;
  logic [7:5]   BASE_RAM;
  logic         RAM_CONFIGURED_n;
  logic         CFGOUT_n;
  state_t       dbg_state;

  modport slave (
    input  A, D_IN, RW_n, AS_n, UDS_n, LDS_n, DS_n, CFGIN_n, JP4,
    output D_OUT, D_OE, BASE_RAM, RAM_CONFIGURED_n, CFGOUT_n, dbg_state
  );

  modport master (
    output A, D_IN, RW_n, AS_n, UDS_n, LDS_n, DS_n, CFGIN_n, JP4,
    input  D_OUT, D_OE, BASE_RAM, RAM_CONFIGURED_n, CFGOUT_n, dbg_state
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for an active-low asynchronous strobe; idles high out of reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/autoconfig_z2.sv
// Zorro II AutoConfig responder for the on-card Fast RAM: answers the $E8 page
// while unconfigured, captures the base address and passes the config chain on.
module autoconfig_z2
  import autoconfig_pkg::*;
#(
  parameter logic [15:0] MANUFACTURER_ID = 16'h07DB,
  parameter logic [7:0]  PRODUCT_ID      = 8'h01,
  parameter logic [31:0] SERIAL_NO       = 32'h0000_0001
) (
  input logic            CLK,
  input logic            RESET_n,
  autoconfig_z2_if.slave bus
);

  logic as_s;
  logic ds_s;

  sync2 u_sync_as (.clk(CLK), .rst_n(RESET_n), .d(bus.AS_n), .q(as_s));
  sync2 u_sync_ds (.clk(CLK), .rst_n(RESET_n), .d(bus.DS_n), .q(ds_s));

  state_t       state_q,   state_d;
  logic [2:0]   base_q,    base_d;
  logic         ack_q,     ack_d;
  logic         rd_en_q,   rd_en_d;
  logic [3:0]   dout_q,    dout_d;
  logic         as_prev_q, as_prev_d;

  logic [6:0] ofs;
  logic       page_hit;
  logic       hit;
  logic       as_fall;
  logic       wr_strobe;

  assign ofs       = {bus.A[6:1], 1'b0};
  assign page_hit  = (bus.A[23:16] == AUTOCFG_PAGE);
  assign hit       = !as_s && page_hit && !bus.CFGIN_n && (state_q == UNCONF);
  assign as_fall   = as_prev_q && !as_s;
  assign wr_strobe = !as_s && !ds_s && !bus.RW_n && !ack_q;

  // Offsets $00/$02 read back true; all other AutoConfig registers are stored inverted.
  function automatic logic [3:0] rom_nibble(input logic [6:0] o, input logic jp4);
    logic [3:0] raw;
    logic [6:0] rel;
    raw = 4'h0;
    rel = o - 7'h18;
    case (o)
      7'h00: raw = TYPE_NIBBLE;
      7'h02: raw = jp4 ? 4'h0 : 4'h7;
      7'h04: raw = PRODUCT_ID[7:4];
      7'h06: raw = PRODUCT_ID[3:0];
      7'h08: raw = 4'h8;
      7'h0A: raw = 4'h0;
      7'h10, 7'h12, 7'h14, 7'h16:
        raw = pick_nibble({16'h0000, MANUFACTURER_ID}, {1'b1, o[2:1]});
      7'h18, 7'h1A, 7'h1C, 7'h1E, 7'h20, 7'h22, 7'h24, 7'h26:
        raw = pick_nibble(SERIAL_NO, rel[3:1]);
      default: raw = 4'h0;
    endcase
    return ((o == 7'h00) || (o == 7'h02)) ? raw : ~raw;
  endfunction

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    ack_d     = ack_q;
    rd_en_d   = rd_en_q;
    dout_d    = dout_q;
    as_prev_d = as_s;

    if (as_s) begin
      ack_d   = 1'b0;
      rd_en_d = 1'b0;
    end

    if (as_fall) begin
      rd_en_d = hit && bus.RW_n;
      if (hit && bus.RW_n) begin
        dout_d = rom_nibble(ofs, bus.JP4);
      end
    end

    // One write per bus cycle; ack holds off re-triggering on a stretched DS_n.
    if (wr_strobe) begin
      ack_d = 1'b1;
      if (hit) begin
        case (ofs)
          OFS_BASE: begin
            state_d = CONFIG;
            base_d  = bus.D_IN[15:13];
          end
          OFS_SHUTUP:  state_d = SHUTUP;
          OFS_BASE_LO: ;
          default:     ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= UNCONF;
      base_q    <= 3'b000;
      ack_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      dout_q    <= 4'h0;
      as_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      ack_q     <= ack_d;
      rd_en_q   <= rd_en_d;
      dout_q    <= dout_d;
      as_prev_q <= as_prev_d;
    end
  end

  // The raw AS_n term releases the bus without waiting for the synchronizer.
  assign bus.D_OUT            = dout_q;
  assign bus.D_OE             = rd_en_q & ~bus.AS_n;
  assign bus.BASE_RAM         = base_q;
  assign bus.RAM_CONFIGURED_n = (state_q != CONFIG);
  assign bus.CFGOUT_n         = (state_q == UNCONF);
  assign bus.dbg_state        = state_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.UDS_n, bus.LDS_n, bus.A[15:7], bus.D_IN[12]};

endmodule

// File: tb/tb_autoconfig_z2.sv
// Self-checking bench for autoconfig_z2: directed AutoConfig sequences plus
// randomized bus cycles checked every cycle against a transaction-level model.
module tb_autoconfig_z2;

  localparam logic [15:0] MFG  = 16'h07DB;
  localparam logic [7:0]  PROD = 8'h01;
  localparam logic [31:0] SER  = 32'h0000_0001;

  localparam int M_UNCONF = 0;
  localparam int M_CONFIG = 1;
  localparam int M_SHUT   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  autoconfig_z2_if bus ();

  autoconfig_z2 #(
    .MANUFACTURER_ID(MFG),
    .PRODUCT_ID     (PROD),
    .SERIAL_NO      (SER)
  ) dut (
    .CLK    (clk),
    .RESET_n(rst_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  int         m_state = M_UNCONF;
  logic [4:0] exp_q[$];          // {base[2:0], ram_configured_n, cfgout_n}
  int         exp_cyc_q[$];
  logic [4:0] cur_exp = 5'b000_1_1;
  int         rd_arm  = -1;
  logic [3:0] rd_nib  = 4'h0;
  logic       exp_oe;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // AutoConfig register image built straight from the register map.
  function automatic logic [3:0] model_nib(input logic [6:0] ofs, input logic jp4);
    logic [3:0] tbl [0:63];
    int i;
    for (int k = 0; k < 64; k++) tbl[k] = 4'h0;
    tbl[0] = 4'hE;
    tbl[1] = jp4 ? 4'h0 : 4'h7;
    tbl[2] = PROD[7:4];
    tbl[3] = PROD[3:0];
    tbl[4] = 4'h8;
    tbl[5] = 4'h0;
    for (int k = 0; k < 4; k++) tbl[8 + k]  = 4'((MFG >> (12 - 4 * k)) & 16'hF);
    for (int k = 0; k < 8; k++) tbl[12 + k] = 4'((SER >> (28 - 4 * k)) & 32'hF);
    i = int'(ofs) / 2;
    return (i < 2) ? tbl[i] : ~tbl[i];
  endfunction

  function automatic bit m_hit(input logic [7:0] page);
    return (page == 8'hE8) && (bus.CFGIN_n == 1'b0) && (m_state == M_UNCONF);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cyc_q.delete();
      cur_exp = 5'b000_1_1;
    end
    while (exp_cyc_q.size() > 0 && cyc >= exp_cyc_q[0]) begin
      cur_exp = exp_q.pop_front();
      void'(exp_cyc_q.pop_front());
    end
    exp_oe = rst_n && (rd_arm >= 0) && (cyc >= rd_arm) && !bus.AS_n;
    chk("d_oe", {7'h0, bus.D_OE}, {7'h0, exp_oe});
    if (exp_oe) chk("d_out", {4'h0, bus.D_OUT}, {4'h0, rd_nib});
    chk("base_ram", {5'h0, bus.BASE_RAM}, {5'h0, cur_exp[4:2]});
    chk("ram_configured_n", {7'h0, bus.RAM_CONFIGURED_n}, {7'h0, cur_exp[1]});
    chk("cfgout_n", {7'h0, bus.CFGOUT_n}, {7'h0, cur_exp[0]});
  end

  // ---------------- driver tasks ----------------
  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    chk("rst_d_oe", {7'h0, bus.D_OE}, 8'h00);
    chk("rst_d_out", {4'h0, bus.D_OUT}, 8'h00);
    chk("rst_base_ram", {5'h0, bus.BASE_RAM}, 8'h00);
    chk("rst_ram_configured_n", {7'h0, bus.RAM_CONFIGURED_n}, 8'h01);
    chk("rst_cfgout_n", {7'h0, bus.CFGOUT_n}, 8'h01);
    m_state = M_UNCONF;
    rd_arm  = -1;
    exp_q.delete();
    exp_cyc_q.delete();
    cur_exp = 5'b000_1_1;
    bus.AS_n = 1'b1; bus.DS_n = 1'b1; bus.UDS_n = 1'b1; bus.LDS_n = 1'b1; bus.RW_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset_now();
  endtask

  task automatic begin_cycle(input logic [7:0] page, input logic [6:0] ofs,
                             input bit rd, input logic [3:0] nib);
    @(posedge clk);
    #2;
    bus.A    = {page, 9'h000, ofs[6:1]};
    bus.RW_n = rd;
    bus.D_IN = nib;
    @(posedge clk);
    #2;
    bus.AS_n = 1'b0;
    if (rd) begin
      bus.DS_n = 1'b0; bus.UDS_n = 1'b0; bus.LDS_n = 1'b0;
      if (m_hit(page)) begin
        rd_arm = cyc + 3;
        rd_nib = model_nib(ofs, bus.JP4);
      end
    end
  endtask

  task automatic write_strobe(input logic [7:0] page, input logic [6:0] ofs, input logic [3:0] nib);
    @(posedge clk);
    #2;
    bus.DS_n = 1'b0; bus.UDS_n = 1'b0; bus.LDS_n = 1'b0;
    if (m_hit(page)) begin
      if (ofs == 7'h48) begin
        m_state = M_CONFIG;
        exp_q.push_back({nib[3:1], 1'b0, 1'b0});
        exp_cyc_q.push_back(cyc + 3);
      end else if (ofs == 7'h4C) begin
        m_state = M_SHUT;
        exp_q.push_back({3'b000, 1'b1, 1'b0});
        exp_cyc_q.push_back(cyc + 3);
      end
    end
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #2;
    bus.AS_n = 1'b1; bus.DS_n = 1'b1; bus.UDS_n = 1'b1; bus.LDS_n = 1'b1; bus.RW_n = 1'b1;
    rd_arm = -1;
    repeat (4) @(posedge clk);
  endtask

  task automatic bus_read(input logic [7:0] page, input logic [6:0] ofs,
                          output logic oe, output logic [3:0] d);
    begin_cycle(page, ofs, 1'b1, 4'h0);
    repeat (4) @(posedge clk);
    #3;
    oe = bus.D_OE;
    d  = bus.D_OUT;
    end_cycle();
  endtask

  task automatic bus_write(input logic [7:0] page, input logic [6:0] ofs,
                           input logic [3:0] nib, input int hold);
    begin_cycle(page, ofs, 1'b0, nib);
    write_strobe(page, ofs, nib);
    repeat (hold) @(posedge clk);
    end_cycle();
  endtask

  task automatic chk_cfg(input string tag, input logic [2:0] base, input logic ram_n, input logic cfg_n);
    #3;
    chk({tag, "_base"}, {5'h0, bus.BASE_RAM}, {5'h0, base});
    chk({tag, "_ram_n"}, {7'h0, bus.RAM_CONFIGURED_n}, {7'h0, ram_n});
    chk({tag, "_cfgout_n"}, {7'h0, bus.CFGOUT_n}, {7'h0, cfg_n});
  endtask

  // ---------------- stimulus ----------------
  logic       r_oe;
  logic [3:0] r_d;
  logic [3:0] mfg_exp [0:3];

  initial begin
    bus.A = '0; bus.D_IN = 4'h0; bus.RW_n = 1'b1;
    bus.AS_n = 1'b1; bus.DS_n = 1'b1; bus.UDS_n = 1'b1; bus.LDS_n = 1'b1;
    bus.CFGIN_n = 1'b0; bus.JP4 = 1'b1;
    mfg_exp[0] = 4'hF; mfg_exp[1] = 4'h8; mfg_exp[2] = 4'h2; mfg_exp[3] = 4'h4;

    do_reset();

    // Identification reads
    bus_read(8'hE8, 7'h00, r_oe, r_d);
    chk("id00_oe", {7'h0, r_oe}, 8'h01);
    chk("id00", {4'h0, r_d}, 8'h0E);
    bus_read(8'hE8, 7'h02, r_oe, r_d);
    chk("id02_8mb", {4'h0, r_d}, 8'h00);
    bus.JP4 = 1'b0;
    bus_read(8'hE8, 7'h02, r_oe, r_d);
    chk("id02_4mb", {4'h0, r_d}, 8'h07);
    bus.JP4 = 1'b1;

    for (int k = 0; k < 4; k++) begin
      bus_read(8'hE8, 7'(7'h10 + 2 * k), r_oe, r_d);
      chk("mfg_nibble", {4'h0, r_d}, {4'h0, mfg_exp[k]});
    end
    bus_read(8'hE8, 7'h40, r_oe, r_d);
    chk("ofs40", {4'h0, r_d}, 8'h0F);
    bus_read(8'hE7, 7'h00, r_oe, r_d);
    chk("other_page_oe", {7'h0, r_oe}, 8'h00);

    // Reset while a read is driving the bus
    begin_cycle(8'hE8, 7'h00, 1'b1, 4'h0);
    repeat (4) @(posedge clk);
    #3;
    chk("midread_oe", {7'h0, bus.D_OE}, 8'h01);
    reset_now();

    // Base address configuration
    bus_write(8'hE8, 7'h4A, 4'h0, 3);
    chk_cfg("after4a", 3'b000, 1'b1, 1'b1);
    bus_write(8'hE8, 7'h48, 4'h2, 3);
    chk_cfg("config", 3'b001, 1'b0, 1'b0);
    bus_read(8'hE8, 7'h00, r_oe, r_d);
    chk("configured_read_oe", {7'h0, r_oe}, 8'h00);

    // Shut-up
    do_reset();
    bus_write(8'hE8, 7'h4C, 4'h0, 3);
    chk_cfg("shutup", 3'b000, 1'b1, 1'b0);
    bus_write(8'hE8, 7'h48, 4'h6, 3);
    chk_cfg("shutup_48", 3'b000, 1'b1, 1'b0);

    // Configuration chain gating
    do_reset();
    bus.CFGIN_n = 1'b1;
    bus_read(8'hE8, 7'h00, r_oe, r_d);
    chk("cfgin_read_oe", {7'h0, r_oe}, 8'h00);
    bus_write(8'hE8, 7'h48, 4'h4, 3);
    chk_cfg("cfgin_48", 3'b000, 1'b1, 1'b1);
    bus.CFGIN_n = 1'b0;

    // Stretched data strobe: data changes after capture must not leak in
    do_reset();
    begin_cycle(8'hE8, 7'h48, 1'b0, 4'h2);
    write_strobe(8'hE8, 7'h48, 4'h2);
    repeat (5) @(posedge clk);
    #2;
    bus.D_IN = 4'hE;
    repeat (15) @(posedge clk);
    end_cycle();
    chk_cfg("stretch", 3'b001, 1'b0, 1'b0);

    // Reset in the middle of a write cycle after configuration
    begin_cycle(8'hE8, 7'h4A, 1'b0, 4'h0);
    write_strobe(8'hE8, 7'h4A, 4'h0);
    repeat (2) @(posedge clk);
    #3;
    reset_now();

    // Randomized cycles
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 30; i++) begin
        logic [7:0] page;
        logic [6:0] ofs;
        int op;
        op          = $urandom_range(0, 9);
        bus.JP4     = 1'($urandom_range(0, 1));
        bus.CFGIN_n = ($urandom_range(0, 7) == 0);
        page        = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'hE8;
        if (op < 6) begin
          ofs = 7'($urandom_range(0, 63) * 2);
          bus_read(page, ofs, r_oe, r_d);
        end else begin
          case ($urandom_range(0, 3))
            0:       ofs = 7'h48;
            1:       ofs = 7'h4A;
            2:       ofs = 7'h4C;
            default: ofs = 7'($urandom_range(0, 63) * 2);
          endcase
          bus_write(page, ofs, 4'($urandom_range(0, 15)), $urandom_range(2, 6));
        end
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
